// File: rtl/frame_read_scheduler_if.sv
// Bus bundle between the frame read scheduler, its descriptor source and the read-frame consumer.
// Slave is the scheduler side; master is the source/consumer side.
interface frame_read_scheduler_if #(
  parameter int PORTS     = 4,
  parameter int LEN_WIDTH = 16,
  parameter int TAG_WIDTH = 8
);
  logic [PORTS-1:0]           desc_wr;
  logic [PORTS*LEN_WIDTH-1:0] desc_len;
  logic [PORTS*TAG_WIDTH-1:0] desc_tag;
  logic [PORTS-1:0]           desc_full;
  logic [PORTS-1:0]           desc_ovf;
  logic                       rd_ready;
  logic [PORTS-1:0]           read_frame_enb;
  logic [PORTS-1:0]           read_frame_sop;
  logic [PORTS-1:0]           read_frame_eop;
  logic [PORTS*LEN_WIDTH-1:0] read_frame_len;
  logic [PORTS*TAG_WIDTH-1:0] read_frame_tag;
  logic                       err_zero_len;

  modport master (
    output desc_wr, desc_len, desc_tag, rd_ready,
    input  desc_full, desc_ovf, read_frame_enb, read_frame_sop, read_frame_eop,
           read_frame_len, read_frame_tag, err_zero_len
  );

  modport slave (
    input  desc_wr, desc_len, desc_tag, rd_ready,
    output desc_full, desc_ovf, read_frame_enb, read_frame_sop, read_frame_eop,
           read_frame_len, read_frame_tag, err_zero_len
  );
endinterface

// File: rtl/frame_read_scheduler.sv
// Read-side scheduler for the multi-port frame FIFO: per-port descriptor queues, round-robin grant,
// and one-hot beat strobes with sop/eop/len/tag for the granted frame.
module frame_read_scheduler #(
  parameter int FRAME_DATA_WIDTH = 1024,
  parameter int PORTS            = 4,
  parameter int LEN_WIDTH        = 16,
  parameter int TAG_WIDTH        = 8,
  parameter int DESC_DEPTH       = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  frame_read_scheduler_if.slave bus
);
  localparam int BYTES = FRAME_DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int AW    = $clog2(DESC_DEPTH);
  localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [LEN_WIDTH:0] ROUND_UP  = (LEN_WIDTH+1)'(BYTES - 1);
  localparam logic [LEN_WIDTH:0] ONE_BEAT  = (LEN_WIDTH+1)'(1);
  localparam logic [AW:0]        DEPTH_CNT = (AW+1)'(DESC_DEPTH);

  typedef enum logic {IDLE, XFER} state_t;

  typedef struct packed {
    logic [LEN_WIDTH-1:0] len;
    logic [TAG_WIDTH-1:0] tag;
  } desc_t;

  desc_t              mem    [PORTS][DESC_DEPTH];
  logic [AW-1:0]      wr_ptr [PORTS];
  logic [AW-1:0]      rd_ptr [PORTS];
  logic [AW:0]        count  [PORTS];
  logic [PORTS-1:0]   full, nonempty, push, pop, ovf_q;

  state_t             state_q, state_d;
  logic [PW-1:0]      rr_q, port_q, grant_port;
  logic               grant_valid;
  desc_t              head;
  logic [LEN_WIDTH:0] head_beats, beats_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic               first_q, err_q, last_beat, beat;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      full[i]     = (count[i] == DEPTH_CNT);
      nonempty[i] = (count[i] != '0);
      push[i]     = bus.desc_wr[i] && !full[i];
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = '0;
    for (int k = 1; k <= PORTS; k++) begin
      if (!grant_valid && nonempty[(int'(rr_q) + k) % PORTS]) begin
        grant_valid = 1'b1;
        grant_port  = PW'((int'(rr_q) + k) % PORTS);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      pop[i] = (state_q == IDLE) && grant_valid && (grant_port == PW'(i));
    end
  end

  assign head       = mem[grant_port][rd_ptr[grant_port]];
  // One extra bit keeps ceil(len/BYTES) exact for len = 2^LEN_WIDTH-1.
  assign head_beats = ({1'b0, head.len} + ROUND_UP) >> BSH;
  assign last_beat  = (beats_q == ONE_BEAT);
  assign beat       = (state_q == XFER) && bus.rd_ready;

  // NOTE: descriptor storage has no reset; count/pointers define validity, so stale contents are never read.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {bus.desc_len[i*LEN_WIDTH +: LEN_WIDTH], bus.desc_tag[i*TAG_WIDTH +: TAG_WIDTH]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < PORTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
      end
      ovf_q <= ovf_q | (bus.desc_wr & full);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid && head.len != '0) state_d = XFER;
      XFER:    if (beat && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      rr_q    <= PW'(PORTS - 1);
      port_q  <= '0;
      len_q   <= '0;
      tag_q   <= '0;
      beats_q <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && grant_valid && (head.len == '0);
      if (state_q == IDLE && grant_valid) begin
        port_q  <= grant_port;
        rr_q    <= grant_port;
        len_q   <= head.len;
        tag_q   <= head.tag;
        beats_q <= head_beats;
        first_q <= 1'b1;
      end else if (beat) begin
        beats_q <= beats_q - ONE_BEAT;
        first_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.read_frame_enb = '0;
    bus.read_frame_sop = '0;
    bus.read_frame_eop = '0;
    bus.read_frame_len = '0;
    bus.read_frame_tag = '0;
    if (state_q == XFER) begin
      bus.read_frame_enb[port_q] = bus.rd_ready;
      bus.read_frame_sop[port_q] = bus.rd_ready && first_q;
      bus.read_frame_eop[port_q] = bus.rd_ready && last_beat;
      bus.read_frame_len[int'(port_q)*LEN_WIDTH +: LEN_WIDTH] = len_q;
      bus.read_frame_tag[int'(port_q)*TAG_WIDTH +: TAG_WIDTH] = tag_q;
    end
  end

  assign bus.desc_full    = full;
  assign bus.desc_ovf     = ovf_q;
  assign bus.err_zero_len = err_q;
endmodule

// File: tb/tb_frame_read_scheduler.sv
// Self-checking bench for frame_read_scheduler: descriptor table plus hand-built corner sequences,
// with a beat scoreboard checked on the falling clock edge.
module tb_frame_read_scheduler;
  localparam int PORTS = 4;
  localparam int LW    = 16;
  localparam int TW    = 8;
  localparam int BYTES = 128;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  frame_read_scheduler_if #(.PORTS(PORTS), .LEN_WIDTH(LW), .TAG_WIDTH(TW)) bus ();

  frame_read_scheduler #(
    .FRAME_DATA_WIDTH(1024), .PORTS(PORTS), .LEN_WIDTH(LW), .TAG_WIDTH(TW), .DESC_DEPTH(4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int       port;
    bit       sop;
    bit       eop;
    int       len;
    int       tag;
  } beat_t;

  typedef struct {
    int port;
    int len;
    int tag;
    int beats;
  } vec_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    err_seen = 0;
  bit    gap_check = 1'b0;
  bit    have_eop = 1'b0;
  int    last_eop_cyc = 0;

  beat_t                e;
  logic [PORTS-1:0]     exp_enb, exp_sop, exp_eop;
  logic [PORTS*LW-1:0]  exp_len;
  logic [PORTS*TW-1:0]  exp_tag;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Scoreboard: every strobe cycle must match the next expected beat.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (bus.err_zero_len) err_seen++;
      if (bus.read_frame_enb != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 128'(bus.read_frame_enb), 128'(0));
        end else begin
          e = sb.pop_front();
          exp_enb = '0;
          exp_enb[e.port] = 1'b1;
          exp_sop = e.sop ? exp_enb : '0;
          exp_eop = e.eop ? exp_enb : '0;
          exp_len = '0;
          exp_len[e.port*LW +: LW] = LW'(e.len);
          exp_tag = '0;
          exp_tag[e.port*TW +: TW] = TW'(e.tag);
          check("enb", 128'(bus.read_frame_enb), 128'(exp_enb));
          check("sop", 128'(bus.read_frame_sop), 128'(exp_sop));
          check("eop", 128'(bus.read_frame_eop), 128'(exp_eop));
          check("len", 128'(bus.read_frame_len), 128'(exp_len));
          check("tag", 128'(bus.read_frame_tag), 128'(exp_tag));
          check("enb_needs_ready", 128'(bus.rd_ready), 128'(1));
          if (gap_check && e.sop && have_eop) check("bubble_gap", 128'(cyc - last_eop_cyc), 128'(2));
          if (e.eop) begin
            have_eop = 1'b1;
            last_eop_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic expect_frame(input int port, input int len, input int tag, input int beats);
    for (int b = 0; b < beats; b++) begin
      sb.push_back('{port: port, sop: (b == 0), eop: (b == beats - 1), len: len, tag: tag});
    end
  endtask

  task automatic push_one(input int port, input int len, input int tag);
    bus.desc_wr = '0;
    bus.desc_wr[port] = 1'b1;
    bus.desc_len[port*LW +: LW] = LW'(len);
    bus.desc_tag[port*TW +: TW] = TW'(tag);
    @(posedge sys_clk);
    #1;
    bus.desc_wr = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge sys_clk);
    #1;
    check(name, 128'(sb.size()), 128'(0));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_enb"}, 128'(bus.read_frame_enb), 128'(0));
    check({name, "_sop_eop"}, 128'({bus.read_frame_sop, bus.read_frame_eop}), 128'(0));
    check({name, "_len_tag"}, 128'({bus.read_frame_len, bus.read_frame_tag}), 128'(0));
    check({name, "_full_ovf"}, 128'({bus.desc_full, bus.desc_ovf}), 128'(0));
    check({name, "_err"}, 128'(bus.err_zero_len), 128'(0));
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    bus.desc_wr = '0;
    bus.rd_ready = 1'b1;
    sb.delete();
    repeat (3) @(posedge sys_clk);
    #1;
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  vec_t vecs[8];
  int   nbeats;
  int   err_base;
  int   active;
  int   plen;

  initial begin
    vecs[0] = '{port: 0, len: 300,   tag: 8'hA1, beats: 3};
    vecs[1] = '{port: 1, len: 128,   tag: 8'h11, beats: 1};
    vecs[2] = '{port: 2, len: 129,   tag: 8'h22, beats: 2};
    vecs[3] = '{port: 3, len: 1,     tag: 8'h33, beats: 1};
    vecs[4] = '{port: 0, len: 65535, tag: 8'hFF, beats: 512};
    vecs[5] = '{port: 1, len: 512,   tag: 8'h5C, beats: 4};
    vecs[6] = '{port: 2, len: 256,   tag: 8'h6D, beats: 2};
    vecs[7] = '{port: 3, len: 127,   tag: 8'h7E, beats: 1};

    bus.desc_len = '0;
    bus.desc_tag = '0;
    do_reset();

    // Table of single frames, full-rate ready.
    for (int v = 0; v < 8; v++) begin
      expect_frame(vecs[v].port, vecs[v].len, vecs[v].tag, vecs[v].beats);
      push_one(vecs[v].port, vecs[v].len, vecs[v].tag);
      wait_drain("table_drain", 1000);
    end

    // Four simultaneous single-beat frames: order 0..3, one bubble between.
    do_reset();
    have_eop = 1'b0;
    gap_check = 1'b1;
    for (int p = 0; p < PORTS; p++) begin
      expect_frame(p, 128, 8'h90 + p, 1);
      bus.desc_len[p*LW +: LW] = 16'd128;
      bus.desc_tag[p*TW +: TW] = TW'(8'h90 + p);
    end
    bus.desc_wr = '1;
    @(posedge sys_clk);
    #1;
    bus.desc_wr = '0;
    wait_drain("rr_drain", 50);
    gap_check = 1'b0;

    // Stall on XFER cycles 2-3 of a 4-beat frame.
    expect_frame(0, 512, 8'h3C, 4);
    push_one(0, 512, 8'h3C);
    active = 0;
    for (int i = 0; i < 20 && active == 0; i++) begin
      @(negedge sys_clk);
      if (bus.read_frame_enb[0]) active = 1;
    end
    check("stall_first_beat_seen", 128'(active), 128'(1));
    @(posedge sys_clk);
    #1;
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      check("stall_no_strobe", 128'({bus.read_frame_enb, bus.read_frame_sop, bus.read_frame_eop}), 128'(0));
      @(posedge sys_clk);
      #1;
    end
    bus.rd_ready = 1'b1;
    wait_drain("stall_drain", 50);

    // Fill port 1 while the scheduler is parked on a stalled port-0 frame.
    bus.rd_ready = 1'b0;
    expect_frame(0, 256, 8'h50, 2);
    push_one(0, 256, 8'h50);
    repeat (3) @(posedge sys_clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) expect_frame(1, 128 * (k + 1), 8'h40 + k, k + 1);
      push_one(1, 128 * (k + 1), 8'h40 + k);
      check("full_after_push", 128'(bus.desc_full[1]), 128'(k >= 3));
      check("ovf_after_push", 128'(bus.desc_ovf[1]), 128'(k == 4));
    end
    bus.rd_ready = 1'b1;
    wait_drain("full_drain", 100);
    check("full_cleared", 128'(bus.desc_full), 128'(0));
    check("ovf_sticky", 128'(bus.desc_ovf), 128'(4'b0010));

    // Zero-length descriptor followed by a one-byte frame.
    err_base = err_seen;
    expect_frame(2, 1, 8'h5B, 1);
    push_one(2, 0, 8'h5A);
    push_one(2, 1, 8'h5B);
    wait_drain("zero_len_drain", 50);
    repeat (3) @(posedge sys_clk);
    #1;
    check("zero_len_pulses", 128'(err_seen - err_base), 128'(1));

    // Random ready pattern, one frame at a time.
    for (int f = 0; f < 5; f++) begin
      plen = $urandom_range(700, 1);
      nbeats = (plen + BYTES - 1) / BYTES;
      expect_frame(f % PORTS, plen, 8'hC0 + f, nbeats);
      push_one(f % PORTS, plen, 8'hC0 + f);
      for (int i = 0; i < 200 && sb.size() != 0; i++) begin
        bus.rd_ready = 1'($urandom_range(1, 0));
        @(posedge sys_clk);
        #1;
      end
      bus.rd_ready = 1'b1;
      wait_drain("random_drain", 50);
    end

    // Reset during beat 2 of a 4-beat frame with another descriptor queued.
    expect_frame(0, 512, 8'h66, 4);
    push_one(0, 512, 8'h66);
    push_one(3, 128, 8'h77);
    active = 0;
    for (int i = 0; i < 20 && active < 2; i++) begin
      @(negedge sys_clk);
      if (bus.read_frame_enb[0]) active++;
    end
    check("abort_beats_seen", 128'(active), 128'(2));
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    sb.delete();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    active = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (bus.read_frame_enb != '0) active++;
    end
    check("no_residual_strobes", 128'(active), 128'(0));
    check("queues_empty_full", 128'(bus.desc_full), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
